// File: rtl/regs_mp_pkg.sv
// Shared defaults and packing helper for the multi-port register file.
package regs_mp_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regs_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a registered popcount.
module regs_mp_scoreboard
  import regs_mp_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mark_en,
  input  logic [ADDR_W-1:0]         mark_addr,
  input  logic                      clr_en,
  input  logic [ADDR_W-1:0]         clr_addr,
  output logic [(1 << ADDR_W)-1:0]  pend,
  output logic [ADDR_W:0]           pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             inc;
  logic             dec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (mark_en && !((ZERO_REG != 0) && mark_addr == '0))
      set_vec[mark_addr] = 1'b1;
    if (clr_en)
      clr_vec[clr_addr] = 1'b1;
  end

  // Set beats clear on the same register, so a clear only counts when not re-set.
  assign inc = |(set_vec & ~pend);
  assign dec = |(clr_vec & pend & ~set_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= (pend & ~clr_vec) | set_vec;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: rtl/regs_mp.sv
// Register file with NUM_RD combinational reads, two write ports and a pending scoreboard.
// Optional write-through forwarding is enabled by defining REGS_MP_BYPASS_EN.
module regs_mp
  import regs_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  output logic [NUM_RD-1:0]        R_Busy,
  input  logic                     Write_Reg0,
  input  logic [ADDR_W-1:0]        W_Addr0,
  input  logic [DATA_W-1:0]        W_Data0,
  input  logic                     Write_Reg1,
  input  logic [ADDR_W-1:0]        W_Addr1,
  input  logic [DATA_W-1:0]        W_Data1,
  input  logic                     Mark_Pend,
  input  logic [ADDR_W-1:0]        Mark_Addr,
  output logic [ADDR_W:0]          Pend_Cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              w0_ok;
  logic              w1_ok;

  assign w0_ok = Write_Reg0 && !(ZR && W_Addr0 == '0);
  assign w1_ok = Write_Reg1 && !(ZR && W_Addr1 == '0);

  // Port 0 is assigned last so it wins an address conflict with port 1.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (w1_ok) mem[W_Addr1] <= W_Data1;
      if (w0_ok) mem[W_Addr0] <= W_Data0;
    end
  end

  regs_mp_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (CLK),
    .rst       (Reset),
    .mark_en   (Mark_Pend),
    .mark_addr (Mark_Addr),
    .clr_en    (Write_Reg1),
    .clr_addr  (W_Addr1),
    .pend      (pend),
    .pend_cnt  (Pend_Cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = R_Addr[slice_off(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      rb = pend[ra];
`ifdef REGS_MP_BYPASS_EN
      // A returning load clears busy unless a new load to the same register is issued now.
      if (Write_Reg1 && W_Addr1 == ra) begin
        rd = W_Data1;
        if (!(Mark_Pend && Mark_Addr == ra)) rb = 1'b0;
      end
      if (Write_Reg0 && W_Addr0 == ra) rd = W_Data0;
`endif
      if (ZR && ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign R_Data[slice_off(k, DATA_W) +: DATA_W] = rd;
    assign R_Busy[k] = rb;
  end
endmodule

// File: tb/tb_regs_mp.sv
// Directed self-checking bench for regs_mp (default build and a 4-read 64-bit build).
module tb_regs_mp;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [9:0]  R_Addr;
  logic [63:0] R_Data;
  logic [1:0]  R_Busy;
  logic        Write_Reg0, Write_Reg1, Mark_Pend;
  logic [4:0]  W_Addr0, W_Addr1, Mark_Addr;
  logic [31:0] W_Data0, W_Data1;
  logic [5:0]  Pend_Cnt;

  logic [15:0]  R_Addr4;
  logic [255:0] R_Data4;
  logic [3:0]   R_Busy4;
  logic         Write_Reg0_4, Write_Reg1_4, Mark_Pend4;
  logic [3:0]   W_Addr0_4, W_Addr1_4, Mark_Addr4;
  logic [63:0]  W_Data0_4, W_Data1_4;
  logic [4:0]   Pend_Cnt4;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  regs_mp u_dut (
    .CLK(CLK), .Reset(Reset), .R_Addr(R_Addr), .R_Data(R_Data), .R_Busy(R_Busy),
    .Write_Reg0(Write_Reg0), .W_Addr0(W_Addr0), .W_Data0(W_Data0),
    .Write_Reg1(Write_Reg1), .W_Addr1(W_Addr1), .W_Data1(W_Data1),
    .Mark_Pend(Mark_Pend), .Mark_Addr(Mark_Addr), .Pend_Cnt(Pend_Cnt)
  );

  regs_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) u_dut4 (
    .CLK(CLK), .Reset(Reset), .R_Addr(R_Addr4), .R_Data(R_Data4), .R_Busy(R_Busy4),
    .Write_Reg0(Write_Reg0_4), .W_Addr0(W_Addr0_4), .W_Data0(W_Data0_4),
    .Write_Reg1(Write_Reg1_4), .W_Addr1(W_Addr1_4), .W_Data1(W_Data1_4),
    .Mark_Pend(Mark_Pend4), .Mark_Addr(Mark_Addr4), .Pend_Cnt(Pend_Cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Write_Reg0 = 1'b0; Write_Reg1 = 1'b0; Mark_Pend = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    R_Addr = '0; idle();
    W_Addr0 = '0; W_Addr1 = '0; Mark_Addr = '0; W_Data0 = '0; W_Data1 = '0;
    R_Addr4 = '0; Write_Reg0_4 = 1'b0; Write_Reg1_4 = 1'b0; Mark_Pend4 = 1'b0;
    W_Addr0_4 = '0; W_Addr1_4 = '0; Mark_Addr4 = '0; W_Data0_4 = '0; W_Data1_4 = '0;
    repeat (2) step();
    R_Addr = {5'd0, 5'd5};
    #1;
    chk("reset_cnt", 64'(Pend_Cnt), 64'd0);
    chk("reset_rd", 64'(R_Data[31:0]), 64'd0);
    chk("reset_busy", 64'(R_Busy), 64'd0);
    Reset = 1'b0;

    // write r5 and mark r2, then reset between edges
    Write_Reg0 = 1'b1; W_Addr0 = 5'd5; W_Data0 = 32'hDEADBEEF;
    Mark_Pend = 1'b1; Mark_Addr = 5'd2;
    step(); idle(); #1;
    chk("wr_r5", 64'(R_Data[31:0]), 64'hDEADBEEF);
    chk("cnt_r2", 64'(Pend_Cnt), 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_rd", 64'(R_Data[31:0]), 64'd0);
    chk("midrst_cnt", 64'(Pend_Cnt), 64'd0);
    Reset = 1'b0;

    // dual-port conflict on r7
    step();
    Write_Reg0 = 1'b1; W_Addr0 = 5'd7; W_Data0 = 32'h11111111;
    Write_Reg1 = 1'b1; W_Addr1 = 5'd7; W_Data1 = 32'h22222222;
    step(); idle(); R_Addr = {5'd0, 5'd7}; #1;
    chk("conflict_r7", 64'(R_Data[31:0]), 64'h11111111);
    chk("conflict_cnt", 64'(Pend_Cnt), 64'd0);

    // zero register
    Write_Reg0 = 1'b1; W_Addr0 = 5'd0; W_Data0 = 32'hFFFFFFFF;
    Mark_Pend = 1'b1; Mark_Addr = 5'd0; R_Addr = {5'd0, 5'd0}; #1;
    chk("r0_same", 64'(R_Data[31:0]), 64'd0);
    step(); idle(); #1;
    chk("r0_rd", 64'(R_Data[31:0]), 64'd0);
    chk("r0_busy", 64'(R_Busy), 64'd0);
    chk("r0_cnt", 64'(Pend_Cnt), 64'd0);

    // scoreboard
    Mark_Pend = 1'b1; Mark_Addr = 5'd3; step();
    Mark_Addr = 5'd4; step(); idle();
    R_Addr = {5'd4, 5'd3}; #1;
    chk("sb_cnt2", 64'(Pend_Cnt), 64'd2);
    chk("sb_busy34", 64'(R_Busy), 64'h3);
    Write_Reg1 = 1'b1; W_Addr1 = 5'd3; W_Data1 = 32'h33; #1;
`ifdef REGS_MP_BYPASS_EN
    chk("sb_byp_busy", 64'(R_Busy), 64'h2);
    chk("sb_byp_data", 64'(R_Data[31:0]), 64'h33);
`else
    chk("sb_nobyp_busy", 64'(R_Busy), 64'h3);
    chk("sb_nobyp_data", 64'(R_Data[31:0]), 64'h0);
`endif
    step(); idle(); #1;
    chk("sb_cnt1", 64'(Pend_Cnt), 64'd1);
    chk("sb_busy4", 64'(R_Busy), 64'h2);
    chk("sb_r3", 64'(R_Data[31:0]), 64'h33);
    Mark_Pend = 1'b1; Mark_Addr = 5'd4;
    Write_Reg1 = 1'b1; W_Addr1 = 5'd4; W_Data1 = 32'h44; #1;
    chk("sb_setclr_busy", 64'(R_Busy), 64'h2);
    step(); idle(); #1;
    chk("sb_setwin_cnt", 64'(Pend_Cnt), 64'd1);
    chk("sb_setwin_busy", 64'(R_Busy), 64'h2);
    chk("sb_r4_data", 64'(R_Data[63:32]), 64'h44);
    // mark r10 while clearing r4: net zero
    Mark_Pend = 1'b1; Mark_Addr = 5'd10;
    Write_Reg1 = 1'b1; W_Addr1 = 5'd4; W_Data1 = 32'h45;
    step(); idle(); R_Addr = {5'd10, 5'd4}; #1;
    chk("sb_swap_cnt", 64'(Pend_Cnt), 64'd1);
    chk("sb_swap_busy", 64'(R_Busy), 64'h2);
    // clear of a non-pending register
    Write_Reg1 = 1'b1; W_Addr1 = 5'd4; W_Data1 = 32'h46;
    step(); idle(); #1;
    chk("sb_clr_np", 64'(Pend_Cnt), 64'd1);
    // mark of already-pending r10
    Mark_Pend = 1'b1; Mark_Addr = 5'd10;
    step(); idle(); #1;
    chk("sb_remark", 64'(Pend_Cnt), 64'd1);

    // bypass on r9
    Write_Reg0 = 1'b1; W_Addr0 = 5'd9; W_Data0 = 32'h12345678;
    step(); idle();
    R_Addr = {5'd0, 5'd9};
    Write_Reg0 = 1'b1; W_Data0 = 32'hCAFEF00D; #1;
`ifdef REGS_MP_BYPASS_EN
    chk("byp_r9", 64'(R_Data[31:0]), 64'hCAFEF00D);
`else
    chk("nobyp_r9", 64'(R_Data[31:0]), 64'h12345678);
`endif
    step(); idle(); #1;
    chk("r9_after", 64'(R_Data[31:0]), 64'hCAFEF00D);

    // wide 4-read build
    Write_Reg0_4 = 1'b1; W_Addr0_4 = 4'd1; W_Data0_4 = 64'h1111_0000_0000_0001;
    Write_Reg1_4 = 1'b1; W_Addr1_4 = 4'd2; W_Data1_4 = 64'h2222_0000_0000_0002;
    step();
    W_Addr0_4 = 4'd3; W_Data0_4 = 64'h3333_0000_0000_0003;
    W_Addr1_4 = 4'd4; W_Data1_4 = 64'h4444_0000_0000_0004;
    step();
    Write_Reg0_4 = 1'b0; Write_Reg1_4 = 1'b0;
    R_Addr4 = {4'd4, 4'd3, 4'd2, 4'd1}; #1;
    chk("w4_rd0", R_Data4[63:0],    64'h1111_0000_0000_0001);
    chk("w4_rd1", R_Data4[127:64],  64'h2222_0000_0000_0002);
    chk("w4_rd2", R_Data4[191:128], 64'h3333_0000_0000_0003);
    chk("w4_rd3", R_Data4[255:192], 64'h4444_0000_0000_0004);
    Mark_Pend4 = 1'b1; Mark_Addr4 = 4'd0;
    step(); #1;
    chk("w4_r0mark", 64'(Pend_Cnt4), 64'd0);
    for (int i = 1; i < 16; i++) begin
      Mark_Addr4 = 4'(i);
      step();
    end
    #1;
    chk("w4_fill", 64'(Pend_Cnt4), 64'd15);
    chk("w4_busy", 64'(R_Busy4), 64'hF);
    Mark_Addr4 = 4'd15;
    step(); Mark_Pend4 = 1'b0; #1;
    chk("w4_sat", 64'(Pend_Cnt4), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
